// File: rtl/vp_checkpoint_controller.sv
`default_nettype none
// ============================================================================
// Module   : vp_checkpoint_controller
// Purpose  : Tracks one outstanding load at a time. A value prediction is
//            forwarded while the load waits for D-cache data, and the
//            register file is checkpointed when that happens. A correct
//            prediction trains the predictor. A wrong prediction, or no
//            data arriving in time, triggers a one-cycle recovery.
// Ports    : clk, rst_n            clock, synchronous active-low reset
//            ld_req, st_req        memory requests issued this cycle
//            pred_valid, pred_data prediction for the load in ld_req
//            dc_valid, dc_data     D-cache load return
//            take_snapshot         pulse, first cycle of speculation
//            spec_valid, spec_data forwarded prediction
//            mem_hold              memory stage stall (combinational)
//            recover               pulse, restore snapshot and flush
//            vp_train, vp_correct  predictor update pulse and outcome
//            hit_cnt, miss_cnt     saturating prediction statistics
// Revision : 1.0  initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module vp_checkpoint_controller #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_req,
    input  logic                  st_req,
    input  logic                  pred_valid,
    input  logic [DATA_WIDTH-1:0] pred_data,
    input  logic                  dc_valid,
    input  logic [DATA_WIDTH-1:0] dc_data,
    output logic                  take_snapshot,
    output logic                  spec_valid,
    output logic [DATA_WIDTH-1:0] spec_data,
    output logic                  mem_hold,
    output logic                  recover,
    output logic                  vp_train,
    output logic                  vp_correct,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    // Sized to hold TIMEOUT itself, which the counter briefly reaches as it leaves a wait state.
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SPEC    = 2'd1,
        S_NOSPEC  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_spec_data;
    logic                  r_vp_train;
    logic                  r_vp_correct;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic w_waiting;
    logic w_timeout;
    logic w_match;
    logic w_hit_evt;
    logic w_miss_evt;
    logic w_train;
    logic w_latch_pred;

    // ------------------------------------------------------------------
    // Next-state and event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_waiting    = (r_state == S_SPEC) || (r_state == S_NOSPEC);
        w_timeout    = (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1));
        w_match      = (dc_data == r_spec_data);
        w_hit_evt    = 1'b0;
        w_miss_evt   = 1'b0;
        w_train      = 1'b0;
        w_latch_pred = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Returning data with nothing outstanding is ignored.
                if (ld_req) begin
                    if (pred_valid) begin
                        w_next_state = S_SPEC;
                        w_latch_pred = 1'b1;
                    end else begin
                        w_next_state = S_NOSPEC;
                    end
                end
            end
            S_SPEC: begin
                // A load arriving in the same cycle is stalled by mem_hold and replayed later.
                if (dc_valid) begin
                    w_train = 1'b1;
                    if (w_match) begin
                        w_next_state = S_IDLE;
                        w_hit_evt    = 1'b1;
                    end else begin
                        w_next_state = S_RECOVER;
                        w_miss_evt   = 1'b1;
                    end
                end else if (w_timeout) begin
                    // The value never arrived, so the forwarded prediction cannot be trusted.
                    w_next_state = S_RECOVER;
                    w_miss_evt   = 1'b1;
                end
            end
            S_NOSPEC: begin
                if (dc_valid) begin
                    w_next_state = S_IDLE;
                    w_train      = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, latched prediction, pulses and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_spec_data  <= '0;
            r_vp_train   <= 1'b0;
            r_vp_correct <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            // Held at zero outside the wait states, so every wait starts from zero.
            if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_latch_pred) begin
                r_spec_data <= pred_data;
            end
            r_vp_train   <= w_train;
            r_vp_correct <= w_hit_evt;
            if (w_hit_evt && (r_hit_cnt != {CNT_WIDTH{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
            end
            if (w_miss_evt && (r_miss_cnt != {CNT_WIDTH{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The wait counter is zero only in the first cycle of a speculation.
    assign take_snapshot = (r_state == S_SPEC) && (r_wait_cnt == '0);
    assign spec_valid    = (r_state == S_SPEC);
    assign spec_data     = r_spec_data;
    assign mem_hold      = (r_state == S_RECOVER) ||
                           (((r_state == S_SPEC) || (r_state == S_NOSPEC)) && (ld_req || st_req));
    assign recover       = (r_state == S_RECOVER);
    assign vp_train      = r_vp_train;
    assign vp_correct    = r_vp_correct;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

`default_nettype wire

// File: doc/vp_checkpoint_controller.md
VP_CHECKPOINT_CONTROLLER -- requirements
Module: vp_checkpoint_controller

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32): load/prediction data width.
REQ-002 Parameter TIMEOUT, default 64: max cycles to wait for D-cache data after a load issues.
REQ-003 Parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 ld_req  in  1  load issued to D-cache this cycle (valid & mem_action==READ).
REQ-007 st_req  in  1  store issued to D-cache this cycle.
REQ-008 pred_valid  in  1  value predictor has a prediction for the load in ld_req.
REQ-009 pred_data  in  DATA_WIDTH  predicted load value.
REQ-010 dc_valid  in  1  D-cache returns load data this cycle.
REQ-011 dc_data  in  DATA_WIDTH  returned load data.
REQ-012 take_snapshot  out  1  one-cycle pulse: register snapshot captures the register file.
REQ-013 spec_valid  out  1  predicted value is being forwarded.
REQ-014 spec_data  out  DATA_WIDTH  latched predicted value.
REQ-015 mem_hold  out  1  stall the memory stage; new request is not accepted.
REQ-016 recover  out  1  one-cycle pulse: restore snapshot, flush younger instructions.
REQ-017 vp_train  out  1  one-cycle pulse: predictor update with dc_data.
REQ-018 vp_correct  out  1  valid with vp_train; 1 = prediction matched.
REQ-019 hit_cnt, miss_cnt  out  CNT_WIDTH each  saturating counts of correct and wrong predictions.

Function
REQ-020 FSM states: IDLE, SPEC (prediction forwarded, awaiting data), NOSPEC (no prediction, awaiting data), RECOVER.
REQ-021 IDLE, ld_req & pred_valid -> SPEC; latch pred_data into spec_data; take_snapshot=1 in the first SPEC cycle only.
REQ-022 IDLE, ld_req & ~pred_valid -> NOSPEC; no snapshot.
REQ-023 IDLE, st_req alone -> stay IDLE; store needs no tracking.
REQ-024 IDLE, dc_valid -> ignored, no output change.
REQ-025 spec_valid=1 for every cycle in SPEC; 0 in all other states.
REQ-026 mem_hold is combinational: 1 when (state is SPEC or NOSPEC) & (ld_req | st_req), and 1 for the whole RECOVER state; 0 otherwise.
REQ-027 SPEC, dc_valid & dc_data==spec_data -> IDLE; next cycle vp_train=1, vp_correct=1, hit_cnt+1.
REQ-028 SPEC, dc_valid & mismatch -> RECOVER; next cycle recover=1, vp_train=1, vp_correct=0, miss_cnt+1.
REQ-029 RECOVER lasts exactly 1 cycle, then IDLE; ld_req/st_req in RECOVER are ignored because they are held.
REQ-030 NOSPEC, dc_valid -> IDLE; next cycle vp_train=1, vp_correct=0; counters unchanged.
REQ-031 Wait counter clears on entry to SPEC/NOSPEC and increments each waiting cycle; at TIMEOUT with no dc_valid: SPEC -> RECOVER (recover pulse, miss_cnt+1, no vp_train); NOSPEC -> IDLE silently.
REQ-032 Same cycle dc_valid and ld_req in SPEC/NOSPEC: resolve the completing load; new load is held; it is accepted in IDLE at the earliest after replay.
REQ-033 Only one outstanding tracked load; spec_data is stable until the state leaves SPEC.
REQ-034 Counters saturate at all-ones and do not wrap.
REQ-035 Equality compares all DATA_WIDTH bits.

Reset
REQ-036 rst_n=0 at posedge -> state IDLE, wait counter 0, spec_data 0, hit_cnt/miss_cnt 0, all pulse outputs 0.
REQ-037 Reset mid-SPEC or mid-RECOVER aborts with no recover pulse; mem_hold=0 in the cycle after reset.

Verification
REQ-038 ld_req, pred_valid=1, pred_data=0x1234; dc_valid at +3 with 0x1234 -> take_snapshot pulse at +1, spec_valid +1..+3, vp_correct=1 at +4, hit_cnt=1.
REQ-039 Same as REQ-038 but dc_data=0x1235 -> recover pulse at +4, miss_cnt=1, IDLE at +5.
REQ-040 ld_req in SPEC at cycle +2 -> mem_hold=1 at +2; ld_req re-presented in IDLE is accepted.
REQ-041 SPEC with no dc_valid for 64 cycles -> recover pulse, miss_cnt+1, no vp_train.
REQ-042 hit_cnt preloaded to 0xFFFF by 65535 hits, one more hit -> count stays 0xFFFF.
REQ-043 rst_n=0 during SPEC -> IDLE next cycle, spec_valid=0, no recover.
